// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: shared encodings for the memory responder.
//   mem_state_e : FSM state encoding (idle / wait / done), also used by the
//                 control unit's stall logic.
//   mem_op_e    : latched access type (read / write).
//   CntW        : width of the wait-state counter (supports 0..15 waits).
package mem_unit_pkg;

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } mem_state_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } mem_op_e;

endpackage

// File: rtl/mem_array.sv
// mem_array: 2**ADDR_W x DATA_W storage, synchronous write, combinational read.
// Ports:
//   clk   in  : write clock
//   we    in  : write enable, commits wdata to addr on the rising edge
//   addr  in  : shared read/write address
//   wdata in  : write data
//   rdata out : combinational read of addr
// Contents are not reset.
module mem_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_unit.sv
// mem_unit: memory-side responder owning MAR, MBR and the RAM array.
// Accepts a read (MBR_we) or write (RAM_we) in idle, waits WAIT_CYCLES extra
// cycles, performs the array access, then pulses rdy for one cycle.
// Ports:
//   mem_clk / mem_rst : clock, synchronous active-high reset
//   MAR_we, addr_in   : load MAR (idle only)
//   MBR_we            : read request, MBR <= RAM[MAR]
//   RAM_we, data_in   : write request, RAM[MAR] <= data_in
//   mbr_out, mar_out  : MBR / MAR contents
//   busy              : high whenever the FSM is not idle
//   rdy               : one-cycle completion pulse
//   err               : write-protection violation pulse, coincident with rdy
// Optional feature: define MEM_WRPROT_EN to drop writes to addresses <= PROT_TOP
// and flag them on err. Without it every write commits and err stays 0.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] PROT_TOP    = 8'h3F
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    input  logic              MAR_we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              MBR_we,
    input  logic              RAM_we,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] mbr_out,
    output logic [ADDR_W-1:0] mar_out,
    output logic              busy,
    output logic              rdy,
    output logic              err
);

`ifdef MEM_WRPROT_EN
    localparam bit WrProtEn = 1'b1;
`else
    localparam bit WrProtEn = 1'b0;
`endif

    mem_state_e        state_q;
    mem_op_e           op_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mbr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              rdy_q;
    logic              err_q;

    logic              access_now;
    logic              wr_blocked;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    assign access_now = (state_q == StWait) && (cnt_q == '0);
    assign wr_blocked = WrProtEn && (mar_q <= PROT_TOP);
    // Gated by reset so an access aborted on its access edge never commits.
    assign arr_we     = access_now && (op_q == OpWr) && !wr_blocked && !mem_rst;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (mem_clk),
        .we    (arr_we),
        .addr  (mar_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_q <= StIdle;
            op_q    <= OpRd;
            cnt_q   <= '0;
            mar_q   <= '0;
            mbr_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // MAR loads on the same edge a request is accepted, so the
                    // access sees the new address.
                    if (MAR_we) begin
                        mar_q <= addr_in;
                    end
                    if (MBR_we || RAM_we) begin
                        state_q <= StWait;
                        busy_q  <= 1'b1;
                        cnt_q   <= CntW'(WAIT_CYCLES);
                        op_q    <= MBR_we ? OpRd : OpWr;  // read wins when both
                        wdata_q <= data_in;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        if (op_q == OpRd) begin
                            mbr_q <= arr_rdata;
                        end else begin
                            err_q <= wr_blocked;
                        end
                        rdy_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mbr_out = mbr_q;
    assign mar_out = mar_q;
    assign busy    = busy_q;
    assign rdy     = rdy_q;
    assign err     = WrProtEn ? err_q : 1'b0;

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: self-checking bench for mem_unit with a behavioural memory model.
module tb_mem_unit;

    localparam int unsigned WaitCycles = 1;
    localparam int          ExpLat     = WaitCycles + 1;  // edges from request edge to rdy
`ifdef MEM_WRPROT_EN
    localparam bit ProtEn = 1'b1;
`else
    localparam bit ProtEn = 1'b0;
`endif

    logic       mem_clk = 1'b0;
    logic       mem_rst = 1'b0;
    logic       MAR_we  = 1'b0;
    logic [7:0] addr_in = '0;
    logic       MBR_we  = 1'b0;
    logic       RAM_we  = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] mbr_out;
    logic [7:0] mar_out;
    logic       busy;
    logic       rdy;
    logic       err;

    int checks = 0;
    int passes = 0;

    // Behavioural model of array contents and MBR.
    logic [7:0] mem_model [256];
    bit         known     [256];
    logic [7:0] mbr_model;
    bit         mbr_known;

    mem_unit #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .WAIT_CYCLES (WaitCycles),
        .PROT_TOP    (8'h3F)
    ) dut (
        .mem_clk (mem_clk),
        .mem_rst (mem_rst),
        .MAR_we  (MAR_we),
        .addr_in (addr_in),
        .MBR_we  (MBR_we),
        .RAM_we  (RAM_we),
        .data_in (data_in),
        .mbr_out (mbr_out),
        .mar_out (mar_out),
        .busy    (busy),
        .rdy     (rdy),
        .err     (err)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    // Issue one request with MAR load, wait (bounded) for rdy, step one more cycle.
    task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output bit got, output logic [7:0] mbr_at,
                          output logic err_at, output bit busy_ok, output bit after_ok);
        MAR_we = 1'b1; addr_in = a; MBR_we = rd; RAM_we = wr; data_in = d;
        tick();
        MAR_we = 1'b0; MBR_we = 1'b0; RAM_we = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!rdy && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        got = rdy;
        mbr_at = mbr_out;
        err_at = err;
        if (!busy) busy_ok = 1'b0;
        tick();
        after_ok = !rdy && !busy && !err;
    endtask

    task automatic test_reset();
        mem_rst = 1'b1;
        tick();
        tick();
        mem_rst = 1'b0;
        checks++; if (mar_out !== 8'h00) $display("FAIL reset_mar got=%h exp=00", mar_out); else passes++;
        checks++; if (mbr_out !== 8'h00) $display("FAIL reset_mbr got=%h exp=00", mbr_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (rdy !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", rdy); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passes++;
        mbr_model = 8'h00;
        mbr_known = 1'b1;
    endtask

    task automatic test_write();
        int lat; bit got, bok, aok; logic [7:0] m; logic e;
        access(1'b0, 1'b1, 8'h42, 8'hA5, lat, got, m, e, bok, aok);
        checks++; if (!got || lat != ExpLat) $display("FAIL write_latency got=%0d(rdy=%b) exp=%0d", lat, got, ExpLat); else passes++;
        checks++; if (!bok) $display("FAIL write_busy got=low_during_access exp=high"); else passes++;
        checks++; if (!aok) $display("FAIL write_done_pulse got=rdy/busy/err_still_high exp=all_low"); else passes++;
        checks++; if (mbr_out !== mbr_model) $display("FAIL write_mbr_undisturbed got=%h exp=%h", mbr_out, mbr_model); else passes++;
        mem_model[8'h42] = 8'hA5; known[8'h42] = 1'b1;
    endtask

    task automatic test_read_ignore();
        int n; int extra; logic [7:0] m;
        MAR_we = 1'b1; addr_in = 8'h42; MBR_we = 1'b1;
        tick();
        MAR_we = 1'b0;
        n = 0;
        // Keep MBR_we asserted through the busy window; it must be ignored.
        while (!rdy && n < 40) begin
            tick();
            n++;
        end
        MBR_we = 1'b0;
        m = mbr_out;
        checks++; if (!rdy || n != ExpLat) $display("FAIL read_latency got=%0d(rdy=%b) exp=%0d", n, rdy, ExpLat); else passes++;
        checks++; if (m !== mem_model[8'h42]) $display("FAIL read_data got=%h exp=%h", m, mem_model[8'h42]); else passes++;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rdy || busy) extra++;
        end
        checks++; if (extra != 0) $display("FAIL read_busy_ignored got=%0d_extra_cycles exp=0", extra); else passes++;
        checks++; if (mbr_out !== mem_model[8'h42]) $display("FAIL read_hold got=%h exp=%h", mbr_out, mem_model[8'h42]); else passes++;
        mbr_model = mem_model[8'h42];
    endtask

    task automatic test_both();
        int lat; bit got, bok, aok; logic [7:0] m; logic e;
        access(1'b0, 1'b1, 8'h10, 8'h00, lat, got, m, e, bok, aok);
        mem_model[8'h10] = 8'h00; known[8'h10] = 1'b1;
        access(1'b1, 1'b1, 8'h10, 8'hFF, lat, got, m, e, bok, aok);
        checks++; if (!got || m !== 8'h00) $display("FAIL both_read_wins got=%h(rdy=%b) exp=00", m, got); else passes++;
        checks++; if (e !== 1'b0) $display("FAIL both_no_err got=%b exp=0", e); else passes++;
        access(1'b1, 1'b0, 8'h10, 8'h00, lat, got, m, e, bok, aok);
        checks++; if (!got || m !== 8'h00) $display("FAIL both_write_dropped got=%h exp=00", m); else passes++;
        mbr_model = 8'h00;
    endtask

    task automatic test_mar_busy();
        int n; int moved;
        MAR_we = 1'b1; addr_in = 8'h42; MBR_we = 1'b1;
        tick();
        MBR_we = 1'b0;
        addr_in = 8'h20;  // MAR_we stays high while busy
        n = 0; moved = 0;
        while (!rdy && n < 40) begin
            tick();
            n++;
            if (mar_out !== 8'h42) moved++;
        end
        MAR_we = 1'b0;
        checks++; if (moved != 0 || mar_out !== 8'h42) $display("FAIL mar_busy_stable got=%h exp=42", mar_out); else passes++;
        checks++; if (mbr_out !== mem_model[8'h42]) $display("FAIL mar_busy_read got=%h exp=%h", mbr_out, mem_model[8'h42]); else passes++;
        tick();
        MAR_we = 1'b1; addr_in = 8'h20;
        tick();
        MAR_we = 1'b0;
        checks++; if (mar_out !== 8'h20) $display("FAIL mar_idle_load got=%h exp=20", mar_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mar_only_no_access got=busy exp=idle"); else passes++;
        mbr_model = mem_model[8'h42];
    endtask

    task automatic test_reset_mid();
        int lat; bit got, bok, aok; logic [7:0] m; logic e; int pulses;
        access(1'b0, 1'b1, 8'h50, 8'h33, lat, got, m, e, bok, aok);
        mem_model[8'h50] = 8'h33; known[8'h50] = 1'b1;
        MAR_we = 1'b1; addr_in = 8'h50; RAM_we = 1'b1; data_in = 8'h77;
        tick();
        MAR_we = 1'b0; RAM_we = 1'b0;
        mem_rst = 1'b1;
        tick();
        mem_rst = 1'b0;
        checks++; if ({mar_out, mbr_out, busy, rdy, err} !== 19'd0)
            $display("FAIL reset_mid_outputs got=mar%h mbr%h b%b r%b e%b exp=all_zero",
                     mar_out, mbr_out, busy, rdy, err); else passes++;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rdy) pulses++;
        end
        checks++; if (pulses != 0) $display("FAIL reset_mid_no_rdy got=%0d exp=0", pulses); else passes++;
        access(1'b1, 1'b0, 8'h50, 8'h00, lat, got, m, e, bok, aok);
        checks++; if (!got || m !== 8'h33) $display("FAIL reset_mid_not_committed got=%h exp=33", m); else passes++;
        mbr_model = 8'h33; mbr_known = 1'b1;
    endtask

    task automatic test_wrprot();
        int lat; bit got, bok, aok; logic [7:0] m; logic e;
`ifdef MEM_WRPROT_EN
        logic [7:0] before;
        access(1'b1, 1'b0, 8'h3F, 8'h00, lat, got, before, e, bok, aok);
        access(1'b0, 1'b1, 8'h3F, 8'h99, lat, got, m, e, bok, aok);
        checks++; if (!got || e !== 1'b1) $display("FAIL prot_err got=%b(rdy=%b) exp=1", e, got); else passes++;
        checks++; if (!aok) $display("FAIL prot_err_pulse got=still_high exp=low"); else passes++;
        access(1'b1, 1'b0, 8'h3F, 8'h00, lat, got, m, e, bok, aok);
        checks++; if (m !== before) $display("FAIL prot_unchanged got=%h exp=%h", m, before); else passes++;
        mbr_known = 1'b0;
`else
        access(1'b0, 1'b1, 8'h3F, 8'h99, lat, got, m, e, bok, aok);
        checks++; if (!got || e !== 1'b0) $display("FAIL noprot_err got=%b(rdy=%b) exp=0", e, got); else passes++;
        access(1'b1, 1'b0, 8'h3F, 8'h00, lat, got, m, e, bok, aok);
        checks++; if (m !== 8'h99) $display("FAIL noprot_commit got=%h exp=99", m); else passes++;
        mem_model[8'h3F] = 8'h99; known[8'h3F] = 1'b1;
        mbr_model = 8'h99; mbr_known = 1'b1;
`endif
        access(1'b0, 1'b1, 8'h40, 8'h99, lat, got, m, e, bok, aok);
        checks++; if (!got || e !== 1'b0) $display("FAIL unprot_err got=%b(rdy=%b) exp=0", e, got); else passes++;
        access(1'b1, 1'b0, 8'h40, 8'h00, lat, got, m, e, bok, aok);
        checks++; if (m !== 8'h99) $display("FAIL unprot_commit got=%h exp=99", m); else passes++;
        mem_model[8'h40] = 8'h99; known[8'h40] = 1'b1;
        mbr_model = 8'h99; mbr_known = 1'b1;
    endtask

    // Back-to-back random traffic straddling the protection boundary.
    task automatic test_back_to_back();
        int lat; bit got, bok, aok; logic [7:0] m; logic e;
        int kind; bit rd, wr, exp_err; logic [7:0] a, d;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            rd = (kind != 2);
            wr = (kind >= 2);
            a = 8'h38 + 8'($urandom_range(0, 15));
            d = 8'($urandom);
            access(rd, wr, a, d, lat, got, m, e, bok, aok);
            exp_err = !rd && ProtEn && (a <= 8'h3F);
            checks++; if (!got || lat != ExpLat || !bok || !aok)
                $display("FAIL b2b_handshake[%0d] got=lat%0d rdy%b busyok%b doneok%b exp=lat%0d", i, lat, got, bok, aok, ExpLat);
            else passes++;
            checks++; if (e !== exp_err) $display("FAIL b2b_err[%0d] got=%b exp=%b", i, e, exp_err); else passes++;
            if (rd) begin
                if (known[a]) begin
                    checks++; if (m !== mem_model[a]) $display("FAIL b2b_read[%0d] a=%h got=%h exp=%h", i, a, m, mem_model[a]); else passes++;
                    mbr_model = mem_model[a]; mbr_known = 1'b1;
                end else begin
                    mbr_known = 1'b0;
                end
            end else begin
                if (mbr_known) begin
                    checks++; if (m !== mbr_model) $display("FAIL b2b_mbr_hold[%0d] got=%h exp=%h", i, m, mbr_model); else passes++;
                end
                if (!exp_err) begin
                    mem_model[a] = d; known[a] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            known[i] = 1'b0;
            mem_model[i] = 8'h00;
        end
        mbr_model = 8'h00;
        mbr_known = 1'b0;
        tick();
        test_reset();
        test_write();
        test_read_ignore();
        test_both();
        test_mar_busy();
        test_reset_mid();
        test_wrprot();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
